ifu_ic_data_ctl: RTL and testbench
==================================

// Module: ifu_ic_data_ctl
// PURPOSE
//  Sequencer/arbiter in front of the I-cache data array. Shares the array's single rw port
//  between fetch reads, miss-fill line writes (multi-beat) and debug reads/writes.
//  Sits between the IFU fetch/miss-buffer/debug logic and the IC data array ports.
// PARAMETERS
//  ADDR_W   12  array rw address width
//  BEAT_W   2   log2(fill beats per line); line address = ADDR_W-BEAT_W bits
//  DATA_W   71  array word width (64 data + 7 ECC)
// PORTS
//  clock            in   1       core clock
//  reset            in   1       asynchronous, active-high
//  fetch_req        in   1       fetch read request this cycle
//  fetch_addr       in   ADDR_W  fetch read address
//  fetch_gnt        out  1       fetch read issued to array this cycle
//  fill_start       in   1       begin line fill (pulse)
//  fill_line_addr   in   ADDR_W-BEAT_W  line index of fill
//  fill_way         in   2       one-hot target way of fill
//  fill_beat_valid  in   1       fill beat data valid
//  fill_beat_ready  out  1       controller accepts fill beat
//  fill_data_0/1    in   DATA_W  fill beat data, banks 0/1
//  fill_done        out  1       pulse: last beat written
//  dbg_rd_en        in   1       debug read request (pulse)
//  dbg_wr_en        in   1       debug write request (pulse)
//  dbg_addr         in   ADDR_W  debug address
//  dbg_way          in   2       one-hot debug way
//  dbg_wr_data      in   DATA_W  debug write data
//  dbg_busy         out  1       debug request pending/in progress; new pulses ignored
//  dbg_rd_valid     out  1       pulse: dbg_rd_data valid
//  dbg_rd_data      out  DATA_W  captured debug read data (held until next capture)
//  ic_rw_addr       out  ADDR_W  array address
//  ic_rd_en         out  1       array read strobe
//  ic_wr_en         out  2       array per-way write strobe
//  ic_wr_data_0/1   out  DATA_W  array write data
//  ic_debug_rd_en   out  1       array debug read qualifier
//  ic_debug_wr_en   out  1       array debug write qualifier
//  ic_debug_way     out  2       array debug way
//  ic_debug_rd_data in   DATA_W  array debug read data, valid cycle after ic_debug_rd_en
// BEHAVIOUR
//  - States: IDLE, FILL, DBG_WR, DBG_RD, DBG_CAP. Reset -> IDLE; all regs/outputs 0.
//  - Array outputs combinational from state+inputs; unused strobes 0, addr/data 0 when idle.
//  - Debug pulse latched into pend reg (addr/way/data/type) when dbg_busy=0; dbg_busy=pend|state in DBG_*.
//    dbg_rd_en & dbg_wr_en together: treated as write, read dropped.
//  - IDLE priority: fill_start > pending debug > fetch_req.
//    fill_start: latch line/way, beat_cnt=0 -> FILL. Pending wr -> DBG_WR. Pending rd -> DBG_RD.
//    Else fetch_req: fetch_gnt=1, ic_rd_en=1, ic_rw_addr=fetch_addr (same cycle).
//  - FILL: fill_beat_ready=1. On beat_valid: ic_wr_en=fill_way, ic_rw_addr={line,beat_cnt},
//    ic_wr_data_0/1=fill_data_0/1, beat_cnt++. Beat_cnt==2^BEAT_W-1 & valid: fill_done=1
//    same cycle, -> IDLE. Cycles with beat_valid=0: fetch_req may be granted (read).
//    fill_start in FILL ignored. Debug pend held through fill.
//  - DBG_WR (1 cycle): ic_wr_en=dbg_way, ic_debug_wr_en=1, ic_debug_way, addr, wr_data_0=data;
//    clear pend -> IDLE.
//  - DBG_RD (1 cycle): ic_rd_en=1, ic_debug_rd_en=1, way, addr; clear pend -> DBG_CAP.
//  - DBG_CAP: register ic_debug_rd_data; dbg_rd_valid=1 next cycle (read-to-valid = 2 clk after
//    DBG_RD entry); -> IDLE. dbg_busy deasserts on return to IDLE.
//  - fetch_gnt=0 in DBG_* states and FILL beat cycles.
//  - Reset mid-fill/debug: abort, -> IDLE, no fill_done/dbg_rd_valid; pend cleared.
// TESTING
//  - Fetch only: fetch_req=1, addr=0x123 in IDLE -> fetch_gnt=1, ic_rd_en=1, ic_rw_addr=0x123 same cycle.
//  - Fill: start line=0x2A way=01, 4 beats back-to-back -> ic_wr_en=01 at addr 0xA8..0xAB,
//    fill_done on 4th beat, then IDLE.
//  - Fill with gaps: beat_valid low cycle 2 + fetch_req -> fetch granted that cycle; fill completes
//    with beats at 0xA8..0xAB in order.
//  - Collision: fill_start + dbg_rd_en same cycle -> fill runs first, dbg_busy=1 throughout,
//    debug read issued after fill_done, dbg_rd_valid 2 cycles later with array data.
//  - Debug write addr=0x010 way=10 data=0x5A -> one cycle ic_debug_wr_en=1, ic_wr_en=10; pulse
//    during dbg_busy ignored.
//  - Reset asserted on beat 2 of fill -> outputs 0 immediately, no fill_done, IDLE after release.

Source files
------------

// File: rtl/ifu_ic_data_ctl.sv
// I-cache data array sequencer: one shared rw port arbitrated between
// fetch reads, multi-beat miss-fill line writes and debug reads/writes.
// Array-side outputs are combinational from state and inputs. Debug
// requests are buffered in a single pending slot until the array is free.
module ifu_ic_data_ctl #(
  parameter int ADDR_W = 12,
  parameter int BEAT_W = 2,
  parameter int DATA_W = 71
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // fetch read port
  input  logic                       fetch_req_i,
  input  logic [ADDR_W-1:0]          fetch_addr_i,
  output logic                       fetch_gnt_o,
  // miss-fill line writes
  input  logic                       fill_start_i,
  input  logic [ADDR_W-BEAT_W-1:0]   fill_line_addr_i,
  input  logic [1:0]                 fill_way_i,
  input  logic                       fill_beat_valid_i,
  output logic                       fill_beat_ready_o,
  input  logic [DATA_W-1:0]          fill_data_0_i,
  input  logic [DATA_W-1:0]          fill_data_1_i,
  output logic                       fill_done_o,
  // debug access
  input  logic                       dbg_rd_en_i,
  input  logic                       dbg_wr_en_i,
  input  logic [ADDR_W-1:0]          dbg_addr_i,
  input  logic [1:0]                 dbg_way_i,
  input  logic [DATA_W-1:0]          dbg_wr_data_i,
  output logic                       dbg_busy_o,
  output logic                       dbg_rd_valid_o,
  output logic [DATA_W-1:0]          dbg_rd_data_o,
  // data array port
  output logic [ADDR_W-1:0]          ic_rw_addr_o,
  output logic                       ic_rd_en_o,
  output logic [1:0]                 ic_wr_en_o,
  output logic [DATA_W-1:0]          ic_wr_data_0_o,
  output logic [DATA_W-1:0]          ic_wr_data_1_o,
  output logic                       ic_debug_rd_en_o,
  output logic                       ic_debug_wr_en_o,
  output logic [1:0]                 ic_debug_way_o,
  input  logic [DATA_W-1:0]          ic_debug_rd_data_i
);

  localparam int LINE_W = ADDR_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = {BEAT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DBG_WR,
    DBG_RD,
    DBG_CAP
  } state_e;

  state_e              state_q, state_d;

  // fill context
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;
  logic [1:0]          fill_way_q, fill_way_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

  // single pending debug request slot
  logic                pend_vld_q, pend_vld_d;
  logic                pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [1:0]          pend_way_q, pend_way_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;

  // debug read return
  logic                dbg_rd_valid_q, dbg_rd_valid_d;
  logic [DATA_W-1:0]   dbg_rd_data_q, dbg_rd_data_d;

  logic                in_dbg_state;
  logic                dbg_accept;
  logic                pend_clr;

  assign in_dbg_state = (state_q == DBG_WR) || (state_q == DBG_RD) || (state_q == DBG_CAP);
  assign dbg_busy_o   = pend_vld_q || in_dbg_state;

  // A new pulse is only taken when nothing is queued or in flight; a
  // simultaneous read+write is treated as a write.
  assign dbg_accept = !dbg_busy_o && (dbg_rd_en_i || dbg_wr_en_i);
  assign pend_clr   = (state_q == DBG_WR) || (state_q == DBG_RD);

  assign dbg_rd_valid_o = dbg_rd_valid_q;
  assign dbg_rd_data_o  = dbg_rd_data_q;

  // Pending debug slot: load on accepted pulse, drop once issued to the array
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_way_d  = pend_way_q;
    pend_data_d = pend_data_q;
    if (dbg_accept) begin
      pend_vld_d  = 1'b1;
      pend_wr_d   = dbg_wr_en_i;
      pend_addr_d = dbg_addr_i;
      pend_way_d  = dbg_way_i;
      pend_data_d = dbg_wr_data_i;
    end else if (pend_clr) begin
      pend_vld_d  = 1'b0;
    end
  end

  // Debug read return: array data is valid during DBG_CAP, presented next cycle
  always_comb begin
    dbg_rd_valid_d = (state_q == DBG_CAP);
    dbg_rd_data_d  = (state_q == DBG_CAP) ? ic_debug_rd_data_i : dbg_rd_data_q;
  end

  // Next-state and array-port drive
  always_comb begin
    state_d           = state_q;
    fill_line_d       = fill_line_q;
    fill_way_d        = fill_way_q;
    beat_cnt_d        = beat_cnt_q;
    fetch_gnt_o       = 1'b0;
    fill_beat_ready_o = 1'b0;
    fill_done_o       = 1'b0;
    ic_rw_addr_o      = '0;
    ic_rd_en_o        = 1'b0;
    ic_wr_en_o        = '0;
    ic_wr_data_0_o    = '0;
    ic_wr_data_1_o    = '0;
    ic_debug_rd_en_o  = 1'b0;
    ic_debug_wr_en_o  = 1'b0;
    ic_debug_way_o    = '0;

    case (state_q)
      IDLE: begin
        // fill beats a queued debug op, which beats a fetch
        if (fill_start_i) begin
          state_d     = FILL;
          fill_line_d = fill_line_addr_i;
          fill_way_d  = fill_way_i;
          beat_cnt_d  = '0;
        end else if (pend_vld_q) begin
          state_d = pend_wr_q ? DBG_WR : DBG_RD;
        end else if (fetch_req_i) begin
          fetch_gnt_o  = 1'b1;
          ic_rd_en_o   = 1'b1;
          ic_rw_addr_o = fetch_addr_i;
        end
      end

      FILL: begin
        fill_beat_ready_o = 1'b1;
        if (fill_beat_valid_i) begin
          ic_wr_en_o     = fill_way_q;
          ic_rw_addr_o   = {fill_line_q, beat_cnt_q};
          ic_wr_data_0_o = fill_data_0_i;
          ic_wr_data_1_o = fill_data_1_i;
          beat_cnt_d     = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            fill_done_o = 1'b1;
            state_d     = IDLE;
          end
        end else if (fetch_req_i) begin
          // idle beat slot lets a fetch through without stalling the fill
          fetch_gnt_o  = 1'b1;
          ic_rd_en_o   = 1'b1;
          ic_rw_addr_o = fetch_addr_i;
        end
      end

      DBG_WR: begin
        ic_wr_en_o       = pend_way_q;
        ic_debug_wr_en_o = 1'b1;
        ic_debug_way_o   = pend_way_q;
        ic_rw_addr_o     = pend_addr_q;
        ic_wr_data_0_o   = pend_data_q;
        state_d          = IDLE;
      end

      DBG_RD: begin
        ic_rd_en_o       = 1'b1;
        ic_debug_rd_en_o = 1'b1;
        ic_debug_way_o   = pend_way_q;
        ic_rw_addr_o     = pend_addr_q;
        state_d          = DBG_CAP;
      end

      DBG_CAP: begin
        // array port left idle while the read data comes back
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // outputs forced quiet while reset is held
    if (rst_i) begin
      fetch_gnt_o       = 1'b0;
      fill_beat_ready_o = 1'b0;
      fill_done_o       = 1'b0;
      ic_rw_addr_o      = '0;
      ic_rd_en_o        = 1'b0;
      ic_wr_en_o        = '0;
      ic_wr_data_0_o    = '0;
      ic_wr_data_1_o    = '0;
      ic_debug_rd_en_o  = 1'b0;
      ic_debug_wr_en_o  = 1'b0;
      ic_debug_way_o    = '0;
    end
  end

  // State and fill-context registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fill_line_q <= '0;
      fill_way_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      fill_way_q  <= fill_way_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Pending debug request registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_vld_q  <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_way_q  <= '0;
      pend_data_q <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_way_q  <= pend_way_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Debug read return registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbg_rd_valid_q <= 1'b0;
      dbg_rd_data_q  <= '0;
    end else begin
      dbg_rd_valid_q <= dbg_rd_valid_d;
      dbg_rd_data_q  <= dbg_rd_data_d;
    end
  end

endmodule

// File: tb/tb_ifu_ic_data_ctl.sv
// Randomized bench for ifu_ic_data_ctl with a cycle-timestamp reference
// model: each cycle the expected array-port drive is derived from what
// ownership of the port the rules give (debug issue, capture, fill, fetch).
module tb_ifu_ic_data_ctl;

  localparam int ADDR_W = 12;
  localparam int BEAT_W = 2;
  localparam int DATA_W = 71;
  localparam int LINE_W = ADDR_W - BEAT_W;
  localparam int BEATS  = 1 << BEAT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                fetch_req, fetch_gnt;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fill_start, fill_beat_valid, fill_beat_ready, fill_done;
  logic [LINE_W-1:0]   fill_line_addr;
  logic [1:0]          fill_way;
  logic [DATA_W-1:0]   fill_data_0, fill_data_1;
  logic                dbg_rd_en, dbg_wr_en, dbg_busy, dbg_rd_valid;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [1:0]          dbg_way;
  logic [DATA_W-1:0]   dbg_wr_data, dbg_rd_data;
  logic [ADDR_W-1:0]   ic_rw_addr;
  logic                ic_rd_en, ic_debug_rd_en, ic_debug_wr_en;
  logic [1:0]          ic_wr_en, ic_debug_way;
  logic [DATA_W-1:0]   ic_wr_data_0, ic_wr_data_1, ic_debug_rd_data;

  ifu_ic_data_ctl #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fill_start_i(fill_start), .fill_line_addr_i(fill_line_addr), .fill_way_i(fill_way),
    .fill_beat_valid_i(fill_beat_valid), .fill_beat_ready_o(fill_beat_ready),
    .fill_data_0_i(fill_data_0), .fill_data_1_i(fill_data_1), .fill_done_o(fill_done),
    .dbg_rd_en_i(dbg_rd_en), .dbg_wr_en_i(dbg_wr_en), .dbg_addr_i(dbg_addr),
    .dbg_way_i(dbg_way), .dbg_wr_data_i(dbg_wr_data), .dbg_busy_o(dbg_busy),
    .dbg_rd_valid_o(dbg_rd_valid), .dbg_rd_data_o(dbg_rd_data),
    .ic_rw_addr_o(ic_rw_addr), .ic_rd_en_o(ic_rd_en), .ic_wr_en_o(ic_wr_en),
    .ic_wr_data_0_o(ic_wr_data_0), .ic_wr_data_1_o(ic_wr_data_1),
    .ic_debug_rd_en_o(ic_debug_rd_en), .ic_debug_wr_en_o(ic_debug_wr_en),
    .ic_debug_way_o(ic_debug_way), .ic_debug_rd_data_i(ic_debug_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  // ---------------- reference model ----------------
  bit                m_fill_on;
  int                m_beat;
  logic [LINE_W-1:0] m_line;
  logic [1:0]        m_fway;
  bit                m_pend, m_pwr;
  logic [ADDR_W-1:0] m_paddr;
  logic [1:0]        m_pway;
  logic [DATA_W-1:0] m_pdata;
  int                m_iss_t;    // cycle in which the queued debug op uses the array
  bit                m_iss_wr;
  logic [DATA_W-1:0] m_rdata;

  logic              e_gnt, e_rd, e_drd, e_dwr, e_ready, e_done, e_busy, e_valid;
  logic [1:0]        e_wr, e_dway;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd0, e_wd1, e_rdata;

  task automatic model_reset();
    m_fill_on = 0; m_beat = 0; m_line = '0; m_fway = '0;
    m_pend = 0; m_pwr = 0; m_paddr = '0; m_pway = '0; m_pdata = '0;
    m_iss_t = -100; m_iss_wr = 0; m_rdata = '0;
  endtask

  function automatic bit cap_cycle();
    return !m_iss_wr && (cyc == m_iss_t + 1);
  endfunction

  task automatic model_eval();
    e_gnt = 0; e_rd = 0; e_drd = 0; e_dwr = 0; e_ready = 0; e_done = 0;
    e_busy = 0; e_valid = 0; e_wr = '0; e_dway = '0; e_addr = '0;
    e_wd0 = '0; e_wd1 = '0; e_rdata = '0;
    if (!rst) begin
      e_busy  = m_pend || cap_cycle();
      e_valid = !m_iss_wr && (cyc == m_iss_t + 2);
      e_rdata = m_rdata;
      if (cyc == m_iss_t) begin
        e_dway = m_pway; e_addr = m_paddr;
        if (m_iss_wr) begin
          e_wr = m_pway; e_dwr = 1; e_wd0 = m_pdata;
        end else begin
          e_rd = 1; e_drd = 1;
        end
      end else if (cap_cycle()) begin
        // port idle while debug data returns
      end else if (m_fill_on) begin
        e_ready = 1;
        if (fill_beat_valid) begin
          e_wr   = m_fway;
          e_addr = ADDR_W'(m_line) * BEATS + ADDR_W'(m_beat);
          e_wd0  = fill_data_0;
          e_wd1  = fill_data_1;
          e_done = (m_beat == BEATS - 1);
        end else if (fetch_req) begin
          e_gnt = 1; e_rd = 1; e_addr = fetch_addr;
        end
      end else if (!fill_start && !m_pend && fetch_req) begin
        e_gnt = 1; e_rd = 1; e_addr = fetch_addr;
      end
    end
  endtask

  task automatic model_commit();
    bit busy_now;
    if (rst) begin
      model_reset();
      return;
    end
    busy_now = m_pend || cap_cycle();
    if (cap_cycle()) begin
      m_rdata = ic_debug_rd_data;
      $display("cyc %0d dbg read addr=%h way=%b data=%h", cyc, m_paddr, m_pway, m_rdata);
    end
    if (cyc == m_iss_t) begin
      m_pend = 0;
      if (m_iss_wr) $display("cyc %0d dbg write addr=%h way=%b data=%h", cyc, m_paddr, m_pway, m_pdata);
    end else if (cap_cycle()) begin
      // nothing else happens this cycle
    end else if (m_fill_on) begin
      if (fill_beat_valid) begin
        if (m_beat == BEATS - 1) begin
          m_fill_on = 0;
          $display("cyc %0d fill done line=%h way=%b", cyc, m_line, m_fway);
        end
        m_beat++;
      end
    end else if (fill_start) begin
      m_fill_on = 1; m_beat = 0; m_line = fill_line_addr; m_fway = fill_way;
    end else if (m_pend) begin
      m_iss_t  = cyc + 1;
      m_iss_wr = m_pwr;
    end
    if (!busy_now && (dbg_rd_en || dbg_wr_en)) begin
      m_pend = 1; m_pwr = dbg_wr_en; m_paddr = dbg_addr; m_pway = dbg_way; m_pdata = dbg_wr_data;
    end
  endtask

  task automatic compare();
    check_val("fetch_gnt",   DATA_W'(fetch_gnt),       DATA_W'(e_gnt));
    check_val("ic_rd_en",    DATA_W'(ic_rd_en),        DATA_W'(e_rd));
    check_val("ic_wr_en",    DATA_W'(ic_wr_en),        DATA_W'(e_wr));
    check_val("ic_rw_addr",  DATA_W'(ic_rw_addr),      DATA_W'(e_addr));
    check_val("ic_wdata0",   ic_wr_data_0,             e_wd0);
    check_val("ic_wdata1",   ic_wr_data_1,             e_wd1);
    check_val("ic_dbg_qual", DATA_W'({ic_debug_rd_en, ic_debug_wr_en, ic_debug_way}),
                             DATA_W'({e_drd, e_dwr, e_dway}));
    check_val("fill_ready",  DATA_W'(fill_beat_ready), DATA_W'(e_ready));
    check_val("fill_done",   DATA_W'(fill_done),       DATA_W'(e_done));
    check_val("dbg_busy",    DATA_W'(dbg_busy),        DATA_W'(e_busy));
    check_val("dbg_rd_vld",  DATA_W'(dbg_rd_valid),    DATA_W'(e_valid));
    check_val("dbg_rd_data", dbg_rd_data,              e_rdata);
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, return at negedge
  task automatic step();
    #2;
    model_eval();
    compare();
    @(posedge clk);
    model_commit();
    cyc++;
    @(negedge clk);
    ic_debug_rd_data = rnd_word();
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_addr = '0; fill_start = 0; fill_line_addr = '0; fill_way = '0;
    fill_beat_valid = 0; fill_data_0 = '0; fill_data_1 = '0;
    dbg_rd_en = 0; dbg_wr_en = 0; dbg_addr = '0; dbg_way = '0; dbg_wr_data = '0;
  endtask

  initial begin
    bit seen;
    int wr_cnt;
    model_reset();
    idle_inputs();
    ic_debug_rd_data = rnd_word();
    rst = 1;
    @(negedge clk);
    step();                                   // reset state
    rst = 0;
    step();

    // fetch only
    fetch_req = 1; fetch_addr = 12'h123;
    #1; check_val("dir_fetch_addr", DATA_W'(ic_rw_addr), DATA_W'(12'h123));
    step();
    idle_inputs();

    // fill, back-to-back beats
    fill_start = 1; fill_line_addr = 10'h2A; fill_way = 2'b01;
    step();
    idle_inputs();
    for (int k = 0; k < BEATS; k++) begin
      fill_beat_valid = 1; fill_data_0 = rnd_word(); fill_data_1 = rnd_word();
      #1; check_val("dir_fill_addr", DATA_W'(ic_rw_addr), DATA_W'(12'hA8 + k));
      check_val("dir_fill_done", DATA_W'(fill_done), DATA_W'(k == BEATS - 1));
      step();
    end
    idle_inputs();
    step();

    // fill with a gap carrying a fetch
    fill_start = 1; fill_line_addr = 10'h2A; fill_way = 2'b10;
    step();
    idle_inputs();
    for (int k = 0; k < BEATS + 1; k++) begin
      fill_beat_valid = (k != 1); fetch_req = 1; fetch_addr = 12'h3C0;
      fill_data_0 = rnd_word(); fill_data_1 = rnd_word();
      #1;
      if (k == 1) check_val("dir_gap_gnt", DATA_W'(fetch_gnt), DATA_W'(1));
      step();
    end
    idle_inputs();
    step();

    // fill_start and debug read in the same cycle
    fill_start = 1; fill_line_addr = 10'h155; fill_way = 2'b01;
    dbg_rd_en = 1; dbg_addr = 12'h777; dbg_way = 2'b10;
    step();
    idle_inputs();
    for (int k = 0; k < BEATS; k++) begin
      fill_beat_valid = 1; fill_data_0 = rnd_word(); fill_data_1 = rnd_word();
      step();
    end
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (dbg_rd_valid === 1'b1) seen = 1;
    end
    check_val("dir_coll_rd_valid", DATA_W'(seen), DATA_W'(1));

    // debug write, second pulse while busy must be dropped
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i == 0) begin dbg_wr_en = 1; dbg_addr = 12'h010; dbg_way = 2'b10; dbg_wr_data = 71'h5A; end
      if (i == 1) begin dbg_wr_en = 1; dbg_addr = 12'h020; dbg_way = 2'b01; dbg_wr_data = 71'hFF; end
      #1;
      if (ic_debug_wr_en === 1'b1) begin
        wr_cnt++;
        check_val("dir_dbgwr_data", ic_wr_data_0, 71'h5A);
        check_val("dir_dbgwr_way",  DATA_W'(ic_wr_en), DATA_W'(2'b10));
        check_val("dir_dbgwr_addr", DATA_W'(ic_rw_addr), DATA_W'(12'h010));
      end
      step();
    end
    check_val("dir_dbgwr_count", DATA_W'(wr_cnt), DATA_W'(1));
    idle_inputs();

    // reset on the second fill beat
    fill_start = 1; fill_line_addr = 10'h2A; fill_way = 2'b01;
    step();
    idle_inputs();
    fill_beat_valid = 1; fill_data_0 = rnd_word(); fill_data_1 = rnd_word();
    step();
    rst = 1; fetch_req = 1;
    #1; check_val("dir_rst_wr_en", DATA_W'(ic_wr_en), DATA_W'(0));
    step();
    rst = 0; idle_inputs();
    step();
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 249) == 0);
      fetch_req       = 1'($urandom_range(0, 1));
      fetch_addr      = ADDR_W'($urandom);
      fill_start      = ($urandom_range(0, 14) == 0);
      fill_line_addr  = LINE_W'($urandom);
      fill_way        = 2'(1 << $urandom_range(0, 1));
      fill_beat_valid = ($urandom_range(0, 3) != 0);
      fill_data_0     = rnd_word();
      fill_data_1     = rnd_word();
      dbg_rd_en       = ($urandom_range(0, 9) == 0);
      dbg_wr_en       = ($urandom_range(0, 13) == 0);
      dbg_addr        = ADDR_W'($urandom);
      dbg_way         = 2'(1 << $urandom_range(0, 1));
      dbg_wr_data     = rnd_word();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
